// File: rtl/cache_arbiter_pkg.sv
// rtl/cache_arbiter_pkg.sv - shared LC-3b line/word types and arbiter state encoding
package cache_arbiter_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_datbus;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } lc3b_arb_state;

endpackage

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - arbitrates the physical-memory line port between I-cache and D-cache
// D-side has priority; a starvation counter forces an I grant after STARVE_LIMIT D grants.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_read,
    input  lc3b_word   i_address,
    output lc3b_datbus i_rdata,
    output logic       i_resp,
    input  logic       d_read,
    input  logic       d_write,
    input  lc3b_word   d_address,
    input  lc3b_datbus d_wdata,
    output lc3b_datbus d_rdata,
    output logic       d_resp,
    output logic       pmem_read,
    output logic       pmem_write,
    output lc3b_word   pmem_address,
    output lc3b_datbus pmem_wdata,
    input  lc3b_datbus pmem_rdata,
    input  logic       pmem_resp,
    output logic       arb_busy
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    lc3b_arb_state  state_q, state_d;
    logic [CW-1:0]  starve_cnt_q, starve_cnt_d;
    logic           pmem_read_q, pmem_read_d;
    logic           pmem_write_q, pmem_write_d;
    lc3b_word       pmem_address_q, pmem_address_d;
    lc3b_datbus     pmem_wdata_q, pmem_wdata_d;

    logic d_req;
    logic grant_d;
    logic grant_i;

    assign d_req   = d_read | d_write;
    // Once the counter saturates, a waiting I request wins over D.
    assign grant_d = d_req & ~(i_read & (starve_cnt_q == STARVE_MAX));
    assign grant_i = i_read & ~grant_d;

    always_comb begin
        state_d        = state_q;
        starve_cnt_d   = starve_cnt_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d        = SERVE_D;
                    pmem_write_d   = d_write;
                    pmem_read_d    = ~d_write;
                    pmem_address_d = d_address;
                    pmem_wdata_d   = d_wdata;
                    if (!i_read) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != STARVE_MAX) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (grant_i) begin
                    state_d        = SERVE_I;
                    pmem_read_d    = 1'b1;
                    pmem_write_d   = 1'b0;
                    pmem_address_d = i_address;
                    starve_cnt_d   = '0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_d      = IDLE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                pmem_read_d  = 1'b0;
                pmem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            starve_cnt_q   <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            starve_cnt_q   <= starve_cnt_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
        end
    end

    // Response is routed combinationally so the owner sees it in the same cycle as pmem_resp.
    assign i_resp       = (state_q == SERVE_I) & pmem_resp;
    assign d_resp       = (state_q == SERVE_D) & pmem_resp;
    assign i_rdata      = pmem_rdata;
    assign d_rdata      = pmem_rdata;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;
    assign arb_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - directed self-checking bench for cache_arbiter
module tb_cache_arbiter;
    import cache_arbiter_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       i_read;
    lc3b_word   i_address;
    lc3b_datbus i_rdata;
    logic       i_resp;
    logic       d_read;
    logic       d_write;
    lc3b_word   d_address;
    lc3b_datbus d_wdata;
    lc3b_datbus d_rdata;
    logic       d_resp;
    logic       pmem_read;
    logic       pmem_write;
    lc3b_word   pmem_address;
    lc3b_datbus pmem_wdata;
    lc3b_datbus pmem_rdata;
    logic       pmem_resp;
    logic       arb_busy;

    int n_pass;
    int n_total;

    cache_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .arb_busy     (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_cmd(input string tag, input logic rd, input logic wr, input logic busy);
        chk({tag, ".pmem_read"}, {127'd0, pmem_read}, {127'd0, rd});
        chk({tag, ".pmem_write"}, {127'd0, pmem_write}, {127'd0, wr});
        chk({tag, ".arb_busy"}, {127'd0, arb_busy}, {127'd0, busy});
    endtask

    task automatic chk_resp(input string tag, input logic ir, input logic dr);
        chk({tag, ".i_resp"}, {127'd0, i_resp}, {127'd0, ir});
        chk({tag, ".d_resp"}, {127'd0, d_resp}, {127'd0, dr});
    endtask

    localparam lc3b_datbus LINE_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam lc3b_datbus LINE_B = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam lc3b_datbus WD_A5  = {16{8'hA5}};
    localparam lc3b_datbus WD_3C  = {16{8'h3C}};

    initial begin
        n_pass     = 0;
        n_total    = 0;
        rst_n      = 1'b0;
        i_read     = 1'b0;
        i_address  = '0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_address  = '0;
        d_wdata    = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;

        // Reset state
        @(negedge clk); #1;
        chk_cmd("reset", 1'b0, 1'b0, 1'b0);
        chk_resp("reset", 1'b0, 1'b0);
        chk("reset.pmem_address", {112'd0, pmem_address}, 128'd0);
        chk("reset.pmem_wdata", pmem_wdata, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // I read alone, memory responds in third serve cycle
        @(negedge clk);
        i_read = 1'b1; i_address = 16'h1230;
        #1; chk_cmd("i_alone.pre", 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            chk_cmd("i_alone.wait", 1'b1, 1'b0, 1'b1);
            chk("i_alone.addr", {112'd0, pmem_address}, {112'd0, 16'h1230});
            chk_resp("i_alone.wait", 1'b0, 1'b0);
        end
        @(negedge clk);
        pmem_resp = 1'b1; pmem_rdata = LINE_A;
        #1; chk_cmd("i_alone.resp", 1'b1, 1'b0, 1'b1);
        chk_resp("i_alone.resp", 1'b1, 1'b0);
        chk("i_alone.i_rdata", i_rdata, LINE_A);
        @(negedge clk);
        pmem_resp = 1'b0; i_read = 1'b0;
        #1; chk_cmd("i_alone.after", 1'b0, 1'b0, 1'b0);
        chk_resp("i_alone.after", 1'b0, 1'b0);

        // Simultaneous I read and D write: D first, then I after one dead cycle
        @(negedge clk);
        i_read = 1'b1; i_address = 16'h2000;
        d_write = 1'b1; d_address = 16'h4000; d_wdata = WD_A5;
        @(negedge clk);
        pmem_resp = 1'b1; pmem_rdata = LINE_B;
        #1; chk_cmd("both.d", 1'b0, 1'b1, 1'b1);
        chk("both.d.addr", {112'd0, pmem_address}, {112'd0, 16'h4000});
        chk("both.d.wdata", pmem_wdata, WD_A5);
        chk_resp("both.d", 1'b0, 1'b1);
        chk("both.d_rdata", d_rdata, LINE_B);
        @(negedge clk);
        pmem_resp = 1'b0; d_write = 1'b0;
        #1; chk_cmd("both.dead", 1'b0, 1'b0, 1'b0);
        chk_resp("both.dead", 1'b0, 1'b0);
        @(negedge clk);
        pmem_resp = 1'b1; pmem_rdata = LINE_A;
        #1; chk_cmd("both.i", 1'b1, 1'b0, 1'b1);
        chk("both.i.addr", {112'd0, pmem_address}, {112'd0, 16'h2000});
        chk_resp("both.i", 1'b1, 1'b0);
        @(negedge clk);
        pmem_resp = 1'b0; i_read = 1'b0;
        #1; chk_resp("both.after", 1'b0, 1'b0);

        // Starvation: continuous D reads with I waiting -> 4 D grants, then I, then D
        @(negedge clk);
        i_read = 1'b1; i_address = 16'h3330;
        d_read = 1'b1; d_address = 16'h5550;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            pmem_resp = 1'b1; pmem_rdata = LINE_B;
            #1;
            if (t == 4) begin
                chk_cmd($sformatf("starve%0d.i", t), 1'b1, 1'b0, 1'b1);
                chk($sformatf("starve%0d.addr", t), {112'd0, pmem_address}, {112'd0, 16'h3330});
                chk_resp($sformatf("starve%0d.i", t), 1'b1, 1'b0);
            end else begin
                chk_cmd($sformatf("starve%0d.d", t), 1'b1, 1'b0, 1'b1);
                chk($sformatf("starve%0d.addr", t), {112'd0, pmem_address}, {112'd0, 16'h5550});
                chk_resp($sformatf("starve%0d.d", t), 1'b0, 1'b1);
            end
            @(negedge clk);
            pmem_resp = 1'b0;
            if (t == 4) i_read = 1'b0;
            #1; chk_cmd($sformatf("starve%0d.dead", t), 1'b0, 1'b0, 1'b0);
        end
        d_read = 1'b0;

        // d_read and d_write together are a write
        @(negedge clk);
        d_read = 1'b1; d_write = 1'b1; d_address = 16'h6000; d_wdata = WD_3C;
        @(negedge clk);
        pmem_resp = 1'b1;
        #1; chk_cmd("rw", 1'b0, 1'b1, 1'b1);
        chk("rw.wdata", pmem_wdata, WD_3C);
        chk_resp("rw", 1'b0, 1'b1);
        @(negedge clk);
        pmem_resp = 1'b0; d_read = 1'b0; d_write = 1'b0;

        // Reset asserted mid SERVE_D aborts with no response
        @(negedge clk);
        d_read = 1'b1; d_address = 16'h7000;
        @(negedge clk); #1;
        chk_cmd("abort.pre", 1'b1, 1'b0, 1'b1);
        #2; rst_n = 1'b0; pmem_resp = 1'b1;
        #1; chk_cmd("abort.rst", 1'b0, 1'b0, 1'b0);
        chk_resp("abort.rst", 1'b0, 1'b0);
        chk("abort.addr", {112'd0, pmem_address}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1; pmem_resp = 1'b0;
        @(negedge clk); #1;
        chk_cmd("abort.regrant", 1'b1, 1'b0, 1'b1);
        chk("abort.regrant.addr", {112'd0, pmem_address}, {112'd0, 16'h7000});
        pmem_resp = 1'b1;
        #1; chk_resp("abort.regrant", 1'b0, 1'b1);
        @(negedge clk);
        pmem_resp = 1'b0; d_read = 1'b0;

        // Spurious pmem_resp in IDLE is ignored
        @(negedge clk);
        pmem_resp = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1; chk_cmd("spurious", 1'b0, 1'b0, 1'b0);
            chk_resp("spurious", 1'b0, 1'b0);
            @(negedge clk);
        end
        pmem_resp = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates the single 128-bit physical-memory line port between the instruction-cache miss path (read-only) and the data-cache miss/writeback path (read or write). It latches the winning request, drives the memory port from registers until the memory responds, then routes the response and line data back to the owner. The D-side has priority, and a starvation guard bounds how long the I-side can wait. It sits between the split L1 caches and physical memory (or L2).

## Interface
- STARVE_LIMIT, 4: consecutive D-grants allowed while an I-request waits before I is forced; ≥1.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_read  in  1  I-side line read request; held until i_resp.
- i_address  in  lc3b_word  I-side line address.
- i_rdata  out  lc3b_datbus  line data to I-side.
- i_resp  out  1  one-cycle completion pulse to I-side.
- d_read, d_write  in  1  D-side line read/write requests; held until d_resp.
- d_address  in  lc3b_word  D-side line address.
- d_wdata  in  lc3b_datbus  D-side writeback line.
- d_rdata  out  lc3b_datbus  line data to D-side.
- d_resp  out  1  one-cycle completion pulse to D-side.
- pmem_read, pmem_write  out  1  memory port commands (registered).
- pmem_address  out  lc3b_word  registered address.
- pmem_wdata  out  lc3b_datbus  registered write line.
- pmem_rdata  in  lc3b_datbus  memory line data, valid with pmem_resp.
- pmem_resp  in  1  memory completion.
- arb_busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, SERVE_I, SERVE_D.
- IDLE: evaluate requests each cycle.
  - No request: stay in IDLE.
  - D only: grant D.
  - I only: grant I.
  - Both: grant I if starve_cnt == STARVE_LIMIT, else grant D.
- Grant: next state SERVE_x. Capture the owner's address, the command and (for D) wdata into the pmem_* registers.
- d_read and d_write both high: treated as a write; d_read is ignored for that grant.
- SERVE_x: hold the pmem_* registers constant until pmem_resp.
  - On pmem_resp, pulse x_resp and drive x_rdata = pmem_rdata in that cycle (combinational route).
  - Next state IDLE; the pmem_read/pmem_write registers clear.
- Non-owner x_resp stays 0. Non-owner x_rdata is don't-care; drive it from pmem_rdata for both sides.
- If the owner drops its request mid-transaction, the transaction still completes and the resp pulse is still issued. Upstream protocol forbids this.
- starve_cnt, width $clog2(STARVE_LIMIT+1):
  - On a D grant while i_read is high: +1, saturating at STARVE_LIMIT.
  - On a D grant while i_read is low: cleared.
  - On any I grant: cleared.
- pmem_resp while in IDLE (spurious): ignored; no resp pulses; state unchanged.

## Timing
- Reset, asynchronous: state IDLE, starve_cnt 0, pmem_read/pmem_write 0, pmem_address 0, pmem_wdata 0, i_resp/d_resp 0, arb_busy 0. Reset mid-transaction aborts it with no resp pulse.
- A request sampled in IDLE at edge t puts the pmem command high from t+1 (one cycle of arbitration latency).
- pmem_resp in cycle k gives x_resp in cycle k (zero added latency). The command is low from k+1, and state is IDLE at k+1.
- The earliest next grant is sampled at edge k+1, so the command reasserts in cycle k+2. There is exactly one dead cycle between back-to-back transactions.
- pmem_resp in the first SERVE cycle is legal: the transaction is one memory cycle long.
- Worst-case I-wait with continuous D traffic: STARVE_LIMIT D-transactions, then I.

## Structure
- Add lc3b_arb_state (IDLE, SERVE_I, SERVE_D) to the shared types package; reuse lc3b_word and lc3b_datbus.
- Single module, no sub-module. The starvation counter is small enough to stay inline.

## Test plan
- Reset, then i_read alone with address 0x1230 and memory resp after 3 cycles: pmem_read is high 3 cycles with address 0x1230; i_resp pulses once with i_rdata = the memory line; arb_busy falls the next cycle.
- Simultaneous i_read and d_write (address 0x4000, wdata 0xA5…A5): D is served first with pmem_write and the correct wdata; I is served after one dead cycle; one resp each.
- Continuous D reads with i_read held, STARVE_LIMIT=4: exactly 4 D-grants, then an I-grant, then the counter is 0 and D resumes.
- d_read and d_write both high: pmem_write=1 and pmem_read=0 for that grant.
- rst_n low mid-SERVE_D: all outputs go to 0 immediately with no d_resp; a fresh request after release is granted normally.
- Spurious pmem_resp in IDLE: no resp pulses and no state change.
